// File: rtl/mult_div_unit_pkg.sv
// Shared CPU definitions for the HI/LO multiply-divide path: op encodings,
// iteration counts and small op-class helpers used by decoder, stall unit and md unit.
package mult_div_unit_pkg;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MFHI  = 4'd5,
    OP_MFLO  = 4'd6,
    OP_MTHI  = 4'd7,
    OP_MTLO  = 4'd8
  } md_op_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } md_state_t;

  localparam logic [3:0] MULT_CYCLES = 4'd5;
  localparam logic [3:0] DIV_CYCLES  = 4'd10;

  function automatic logic is_mult_op(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_MULTU);
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Multi-cycle HI/LO unit: fixed 5-cycle multiply, 10-cycle divide, MTHI/MTLO writes.
// Results land in HI/LO only on the completion edge; MFHI/MFLO read combinationally.
module mult_div_unit
  import mult_div_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [3:0]  op,
  input  logic        start,
  input  logic        cancel,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] out
);

  md_state_t   r_state;
  logic [3:0]  r_cnt;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [3:0]  r_op;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  md_state_t   w_state_nxt;
  logic [3:0]  w_cnt_nxt;
  logic [31:0] w_a_nxt;
  logic [31:0] w_b_nxt;
  logic [3:0]  w_op_nxt;
  logic [31:0] w_hi_nxt;
  logic [31:0] w_lo_nxt;

  logic signed [63:0] w_sa;
  logic signed [63:0] w_sb;
  logic [63:0]        w_ua;
  logic [63:0]        w_ub;
  logic signed [63:0] w_prod_s;
  logic [63:0]        w_prod_u;
  logic signed [63:0] w_quot_s;
  logic signed [63:0] w_rem_s;
  logic [63:0]        w_result;
  logic               w_write;
  logic               w_unused;

  // 64-bit signed divide keeps 0x80000000 / -1 well defined (quotient wraps to 0x80000000).
  assign w_sa     = {{32{r_a[31]}}, r_a};
  assign w_sb     = {{32{r_b[31]}}, r_b};
  assign w_ua     = {32'b0, r_a};
  assign w_ub     = {32'b0, r_b};
  assign w_prod_s = w_sa * w_sb;
  assign w_prod_u = w_ua * w_ub;
  assign w_quot_s = (r_b == 32'b0) ? 64'sd0 : (w_sa / w_sb);
  assign w_rem_s  = (r_b == 32'b0) ? 64'sd0 : (w_sa % w_sb);
  assign w_unused = ^{w_quot_s[63:32], w_rem_s[63:32]};

  always_comb begin
    w_result = 64'b0;
    w_write  = 1'b1;
    case (r_op)
      OP_MULT:  w_result = w_prod_s;
      OP_MULTU: w_result = w_prod_u;
      OP_DIV: begin
        w_write  = (r_b != 32'b0);
        w_result = {w_rem_s[31:0], w_quot_s[31:0]};
      end
      OP_DIVU: begin
        w_write  = (r_b != 32'b0);
        w_result = (r_b == 32'b0) ? 64'b0 : {r_a % r_b, r_a / r_b};
      end
      default:  w_write = 1'b0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_op_nxt    = r_op;
    w_hi_nxt    = r_hi;
    w_lo_nxt    = r_lo;
    case (r_state)
      S_IDLE: begin
        if (!cancel) begin
          if (start && (is_mult_op(op) || is_div_op(op))) begin
            w_state_nxt = S_RUN;
            w_a_nxt     = A;
            w_b_nxt     = B;
            w_op_nxt    = op;
            w_cnt_nxt   = is_mult_op(op) ? MULT_CYCLES : DIV_CYCLES;
          end else if (op == OP_MTHI) begin
            w_hi_nxt = A;
          end else if (op == OP_MTLO) begin
            w_lo_nxt = A;
          end
        end
      end
      S_RUN: begin
        // start/MTHI/MTLO are deliberately ignored here; upstream stalls them.
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt == 4'd1) begin
          w_state_nxt = S_IDLE;
          if (w_write) begin
            w_hi_nxt = w_result[63:32];
            w_lo_nxt = w_result[31:0];
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_a     <= 32'b0;
      r_b     <= 32'b0;
      r_op    <= 4'd0;
      r_hi    <= 32'b0;
      r_lo    <= 32'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
      r_op    <= w_op_nxt;
      r_hi    <= w_hi_nxt;
      r_lo    <= w_lo_nxt;
    end
  end

  assign busy = (r_state == S_RUN);
  assign hi   = r_hi;
  assign lo   = r_lo;
  assign out  = (op == OP_MFHI) ? r_hi : r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed vector table, hand-written corner sequences,
// and randomized ops against an arithmetic reference model of HI/LO.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  op;
  logic        start;
  logic        cancel;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] out;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi = 32'b0;
  logic [31:0] m_lo = 32'b0;

  mult_div_unit dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .op(op), .start(start),
    .cancel(cancel), .busy(busy), .hi(hi), .lo(lo), .out(out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          exp_cyc;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: architectural effect of one op, from plain 64-bit arithmetic.
  task automatic model_apply(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                             input logic c, output int cycles);
    longint sa, sb;
    longint unsigned p;
    cycles = 0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (!c) begin
      case (o)
        OP_MULT:  begin p = longint'(sa * sb); m_hi = p[63:32]; m_lo = p[31:0]; cycles = 5; end
        OP_MULTU: begin p = {32'b0, a} * {32'b0, b}; m_hi = p[63:32]; m_lo = p[31:0]; cycles = 5; end
        OP_DIV: begin
          if (b != 0) begin m_lo = 32'(sa / sb); m_hi = 32'(sa % sb); end
          cycles = 10;
        end
        OP_DIVU: begin
          if (b != 0) begin m_lo = a / b; m_hi = a % b; end
          cycles = 10;
        end
        OP_MTHI: m_hi = a;
        OP_MTLO: m_lo = a;
        default: ;
      endcase
    end
  endtask

  // Issue one op at a negedge, count busy cycles, check HI/LO during and after.
  task automatic run_op(input string name, input logic [3:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic c, output int n);
    int exp_cyc;
    logic [31:0] pre_hi, pre_lo;
    pre_hi = m_hi;
    pre_lo = m_lo;
    model_apply(o, a, b, c, exp_cyc);
    @(negedge clk);
    op = o; A = a; B = b; cancel = c;
    start = (o == OP_MULT || o == OP_MULTU || o == OP_DIV || o == OP_DIVU);
    @(negedge clk);
    start = 1'b0; cancel = 1'b0; op = OP_NONE;
    n = 0;
    while (busy === 1'b1 && n < 20) begin
      n++;
      if (n == 2) begin
        chk({name, " mid hi"}, hi, pre_hi);
        op = OP_MFHI;
        #1;
        chk({name, " mid out"}, out, pre_hi);
        op = OP_NONE;
      end
      @(negedge clk);
    end
    chk({name, " busy cycles"}, 32'(n), 32'(exp_cyc));
    chk({name, " hi"}, hi, m_hi);
    chk({name, " lo"}, lo, m_lo);
  endtask

  vec_t vecs[11];
  int   n;
  logic [3:0] rops[6];

  initial begin
    reset = 1'b1; A = 0; B = 0; op = OP_NONE; start = 0; cancel = 0;
    vecs[0]  = '{OP_MULT,  32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE, 5};
    vecs[1]  = '{OP_MULTU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 5};
    vecs[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[3]  = '{OP_DIVU,  32'h00000007, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[4]  = '{OP_MTHI,  32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFD, 0};
    vecs[5]  = '{OP_DIVU,  32'd100,      32'd7,        32'h00000002, 32'h0000000E, 10};
    vecs[6]  = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
    vecs[7]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5};
    vecs[8]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
    vecs[9]  = '{OP_MTLO,  32'h0000BBBB, 32'h00000000, 32'h00000000, 32'h0000BBBB, 0};
    vecs[10] = '{OP_MTHI,  32'hAAAA0000, 32'h00000000, 32'hAAAA0000, 32'h0000BBBB, 0};

    repeat (2) @(negedge clk);
    chk("reset busy", {31'b0, busy}, 32'd0);
    chk("reset hi", hi, 32'd0);
    chk("reset lo", lo, 32'd0);
    chk("reset out", out, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, n);
      chk($sformatf("vec%0d tbl cycles", i), 32'(n), 32'(vecs[i].exp_cyc));
      chk($sformatf("vec%0d tbl hi", i), hi, vecs[i].exp_hi);
      chk($sformatf("vec%0d tbl lo", i), lo, vecs[i].exp_lo);
    end

    op = OP_MFHI; #1;
    chk("mfhi out", out, 32'hAAAA0000);
    op = OP_MFLO; #1;
    chk("mflo out", out, 32'h0000BBBB);
    op = OP_NONE;

    // Reset in the middle of a divide: no late write, busy drops next cycle.
    @(negedge clk);
    op = OP_DIV; A = 32'd100; B = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0; op = OP_NONE;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst mid busy", {31'b0, busy}, 32'd0);
    chk("rst mid hi", hi, 32'd0);
    chk("rst mid lo", lo, 32'd0);
    reset = 1'b0; m_hi = 0; m_lo = 0;
    repeat (12) @(negedge clk);
    chk("rst no late hi", hi, 32'd0);
    chk("rst no late lo", lo, 32'd0);

    // MTLO during a multiply's RUN is dropped.
    model_apply(OP_MULT, 32'd3, 32'd5, 1'b0, n);
    op = OP_MULT; A = 32'd3; B = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0; op = OP_MTLO; A = 32'hDEADBEEF;
    @(negedge clk);
    op = OP_NONE;
    n = 0;
    while (busy === 1'b1 && n < 20) begin n++; @(negedge clk); end
    chk("mtlo in run lo", lo, 32'd15);
    chk("mtlo in run hi", hi, 32'd0);

    // start with cancel never leaves IDLE.
    op = OP_MULT; A = 32'd9; B = 32'd9; start = 1'b1; cancel = 1'b1;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0; op = OP_NONE;
    chk("cancel busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    chk("cancel busy later", {31'b0, busy}, 32'd0);
    chk("cancel lo", lo, 32'd15);

    rops = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO};
    for (int i = 0; i < 60; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = ($urandom_range(0, 9) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(8, 28);
      run_op($sformatf("rnd%0d", i), rops[$urandom_range(0, 5)], ra, rb,
             ($urandom_range(0, 7) == 0), n);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named clk and reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high; clears all state at the clk edge where it is sampled high.
REQ-004 A  input  32  E-stage rs operand, already forwarded (E1 path).
REQ-005 B  input  32  E-stage rt operand, already forwarded (E2 path).
REQ-006 op  input  4  operation code from the shared package: NONE, MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO.
REQ-007 start  input  1  one-cycle pulse that launches MULT/MULTU/DIV/DIVU.
REQ-008 cancel  input  1  E-stage instruction killed (exception/flush); suppresses start and MTHI/MTLO in the same cycle.
REQ-009 busy  output  1  high while a multiply or divide is in flight.
REQ-010 hi  output  32  architectural HI register.
REQ-011 lo  output  32  architectural LO register.
REQ-012 out  output  32  hi when op==MFHI, otherwise lo; combinational, forwarded to the E-stage write-data path.

Function
REQ-013 States SHALL be IDLE and RUN; a down-counter cnt SHALL track the remaining RUN cycles.
REQ-014 In IDLE, with start=1, cancel=0 and op in {MULT,MULTU,DIV,DIVU}, the block SHALL latch A, B and op, enter RUN, and load cnt with 5 for multiply or 10 for divide.
REQ-015 busy SHALL equal (state==RUN); it rises one cycle after start and stays high exactly 5 (multiply) or 10 (divide) cycles.
REQ-016 cnt SHALL decrement once per RUN cycle; on the edge where cnt==1, the block SHALL write HI/LO from the latched operands and return to IDLE.
REQ-017 MULT SHALL produce the signed 64-bit product and MULTU the unsigned one, with {HI,LO} = product.
REQ-018 DIV SHALL write LO = signed quotient truncated toward zero and HI = remainder carrying the dividend's sign; DIVU SHALL do the same unsigned.
REQ-019 A divide by B==0 SHALL still run the full 10 busy cycles and SHALL leave HI/LO unchanged.
REQ-020 MTHI/MTLO in IDLE with cancel=0 SHALL write A to HI/LO at the next edge, with no busy.
REQ-021 start, MTHI and MTLO received while busy=1 SHALL be ignored; the upstream stall logic is responsible for stalling any D-stage md-class instruction while start|busy.
REQ-022 start together with cancel SHALL be ignored, and state SHALL remain IDLE.
REQ-023 hi/lo SHALL change only at the completion edge, on an MTHI/MTLO, or on reset; results are never visible partway through a RUN.
REQ-024 out SHALL reflect the current hi/lo with zero latency; a read during busy returns the pre-operation value.

Reset
REQ-025 When reset=1, the next edge SHALL force state=IDLE, cnt=0, busy=0, hi=0, lo=0 and latched operands=0, overriding start, cancel and any completion in the same cycle.
REQ-026 A reset mid-RUN SHALL abort the operation with no HI/LO write, and busy SHALL be 0 in the following cycle.

Structure
REQ-027 The op encodings and the constants MULT_CYCLES=5 and DIV_CYCLES=10 SHALL live in the shared CPU definitions package, which is also used by the decoder and the stall unit.
REQ-028 The block SHALL be a single module with no sub-modules; the arithmetic SHALL use behavioural signed/unsigned 64-bit multiply and divide on the latched operands.

Verification
REQ-029 MULT A=0xFFFFFFFF B=0x00000002 with start -> busy high 5 cycles, then HI=0xFFFFFFFF and LO=0xFFFFFFFE.
REQ-030 MULTU with the same operands -> HI=0x00000001 and LO=0xFFFFFFFE after 5 busy cycles.
REQ-031 DIV A=0xFFFFFFF9 (-7) B=0x00000002 -> after 10 busy cycles LO=0xFFFFFFFD and HI=0xFFFFFFFF; then DIVU A=7 B=0 -> 10 busy cycles with HI/LO unchanged.
REQ-032 MTHI A=0x12345678 in IDLE -> hi=0x12345678 next cycle; MTLO issued during a MULT's RUN -> ignored, and only the product is written.
REQ-033 Reset asserted at RUN cycle 3 of a DIV -> busy=0, hi=lo=0 next cycle, with no late write; start with cancel=1 -> busy stays 0.
REQ-034 With HI=0xAAAA0000 and LO=0x0000BBBB: op=MFHI -> out=0xAAAA0000, and op=MFLO -> out=0x0000BBBB in the same cycle.
